// File: rtl/uart_rx_8x.sv
// 8x-oversampled UART receiver: start-bit qualification, mid-cell sampling, one-entry valid/ready holding register.
// Optional even-parity checking is compiled in when UART_PARITY_EN is defined.
module uart_rx_8x #(
  parameter int DATA_BITS   = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 sys_clk,
  input  logic                 rst_n,
  input  logic                 bclkx8,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 overrun_err,
  output logic                 parity_err,
  input  logic                 err_clr
);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  state_t                 state_q, state_d;
  logic                   bclk_q;
  logic [SYNC_STAGES-1:0] sync_q;
  logic [2:0]             os_cnt_q, os_cnt_d;
  logic [2:0]             bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic [DATA_BITS-1:0]   data_q, data_d;
  logic                   valid_q, valid_d;
  logic                   ferr_q, ferr_d;
  logic                   oerr_q, oerr_d;
  logic                   tick, rxs, deliver, load, last_bit;

  assign tick     = bclkx8 & ~bclk_q;
  assign rxs      = sync_q[SYNC_STAGES-1];
  assign last_bit = (bit_cnt_q == 3'(DATA_BITS-1));

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (tick) begin
      case (state_q)
        S_IDLE:  if (!rxs) state_d = S_START;
        S_START: if (os_cnt_q == 3'd3) state_d = rxs ? S_IDLE : S_DATA;
`ifdef UART_PARITY_EN
        S_DATA:   if (os_cnt_q == 3'd7 && last_bit) state_d = S_PARITY;
        S_PARITY: if (os_cnt_q == 3'd7) state_d = S_STOP;
`else
        S_DATA:   if (os_cnt_q == 3'd7 && last_bit) state_d = S_STOP;
`endif
        S_STOP:  if (os_cnt_q == 3'd7) state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

`ifdef UART_PARITY_EN
  logic par_q, par_d, perr_q, perr_d;
`endif

  always_comb begin
    os_cnt_d  = os_cnt_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    deliver   = 1'b0;
`ifdef UART_PARITY_EN
    par_d     = par_q;
`endif
    if (tick) begin
      case (state_q)
        S_IDLE: os_cnt_d = 3'd0;
        S_START: begin
          os_cnt_d = (os_cnt_q == 3'd3) ? 3'd0 : os_cnt_q + 3'd1;
          if (os_cnt_q == 3'd3) bit_cnt_d = 3'd0;
        end
        S_DATA: begin
          // 3-bit counter wraps 7 -> 0 on its own at the sample tick
          os_cnt_d = os_cnt_q + 3'd1;
          if (os_cnt_q == 3'd7) begin
            shift_d   = {rxs, shift_q[DATA_BITS-1:1]};
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
`ifdef UART_PARITY_EN
        S_PARITY: begin
          os_cnt_d = os_cnt_q + 3'd1;
          if (os_cnt_q == 3'd7) par_d = rxs;
        end
`endif
        S_STOP: begin
          os_cnt_d = os_cnt_q + 3'd1;
          if (os_cnt_q == 3'd7) deliver = 1'b1;
        end
        default: os_cnt_d = 3'd0;
      endcase
    end
    load    = deliver & (~valid_q | rx_ready);
    data_d  = load ? shift_q : data_q;
    valid_d = load | (valid_q & ~rx_ready);
    // set beats a simultaneous clear
    oerr_d  = (deliver & ~load) | (oerr_q & ~err_clr);
    ferr_d  = (deliver & ~rxs)  | (ferr_q & ~err_clr);
`ifdef UART_PARITY_EN
    perr_d  = (deliver & (^{shift_q, par_q})) | (perr_q & ~err_clr);
`endif
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      bclk_q    <= 1'b1;
      sync_q    <= '1;
      os_cnt_q  <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
      oerr_q    <= 1'b0;
    end else begin
      bclk_q    <= bclkx8;
      sync_q    <= {sync_q[SYNC_STAGES-2:0], rxd};
      os_cnt_q  <= os_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
      oerr_q    <= oerr_d;
    end
  end

`ifdef UART_PARITY_EN
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      par_q  <= 1'b0;
      perr_q <= 1'b0;
    end else begin
      par_q  <= par_d;
      perr_q <= perr_d;
    end
  end
  assign parity_err = perr_q;
`else
  assign parity_err = 1'b0;
`endif

  assign rx_data     = data_q;
  assign rx_valid    = valid_q;
  assign frame_err   = ferr_q;
  assign overrun_err = oerr_q;

endmodule

// File: tb/tb_uart_rx_8x.sv
// Directed bench for uart_rx_8x: 16-cycle bclkx8 period, 128 cycles per bit.
module tb_uart_rx_8x;

  logic       sys_clk = 1'b0;
  logic       rst_n, bclkx8, rxd, rx_ready, err_clr;
  logic [7:0] rx_data;
  logic       rx_valid, frame_err, overrun_err, parity_err;

  int         n_chk = 0, n_err = 0;
  int         hi_cnt = 0, xfer_cnt = 0;
  logic [7:0] last_data = 8'h00;
  logic [3:0] bcnt = 4'd0;
  logic       par_en;

  uart_rx_8x #(.DATA_BITS(8), .SYNC_STAGES(2)) dut (
    .sys_clk(sys_clk), .rst_n(rst_n), .bclkx8(bclkx8), .rxd(rxd),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .frame_err(frame_err), .overrun_err(overrun_err), .parity_err(parity_err),
    .err_clr(err_clr)
  );

  always #5 sys_clk = ~sys_clk;

  always @(posedge sys_clk) bcnt <= bcnt + 4'd1;
  assign bclkx8 = (bcnt < 4'd8);

  always @(negedge sys_clk) begin
    if (rx_valid) hi_cnt++;
    if (rx_valid && rx_ready) begin
      xfer_cnt++;
      last_data = rx_data;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  // A low stop bit is released early so the line is high again before the
  // receiver can re-qualify the tail of the stop cell as a new start bit.
  task automatic send_frame(input logic [7:0] d, input logic stop, input logic pen, input logic par);
    rxd = 1'b0; cyc(128);
    for (int i = 0; i < 8; i++) begin
      rxd = d[i]; cyc(128);
    end
    if (pen) begin
      rxd = par; cyc(128);
    end
    if (stop) begin
      rxd = 1'b1; cyc(128);
    end else begin
      rxd = 1'b0; cyc(96);
      rxd = 1'b1; cyc(32);
    end
  endtask

  initial begin
`ifdef UART_PARITY_EN
    par_en = 1'b1;
`else
    par_en = 1'b0;
`endif
    rst_n = 1'b0; rxd = 1'b1; rx_ready = 1'b1; err_clr = 1'b0;
    cyc(5);
    chk("rst_valid", rx_valid, 0);
    chk("rst_data", rx_data, 0);
    chk("rst_ferr", frame_err, 0);
    chk("rst_oerr", overrun_err, 0);
    chk("rst_perr", parity_err, 0);
    rst_n = 1'b1;
    cyc(50);

    // basic frame
    hi_cnt = 0; xfer_cnt = 0;
    send_frame(8'hA5, 1'b1, par_en, 1'b0);
    cyc(40);
    chk("t1_data", last_data, 8'hA5);
    chk("t1_vld_cycles", hi_cnt, 1);
    chk("t1_ferr", frame_err, 0);
    chk("t1_oerr", overrun_err, 0);
    chk("t1_valid_low", rx_valid, 0);

    // false start: two ticks low
    hi_cnt = 0;
    rxd = 1'b0; cyc(32);
    rxd = 1'b1; cyc(300);
    chk("t2_no_valid", hi_cnt, 0);
    chk("t2_ferr", frame_err, 0);
    chk("t2_oerr", overrun_err, 0);
    chk("t2_perr", parity_err, 0);

    // framing error, then clear
    hi_cnt = 0;
    send_frame(8'h3C, 1'b0, par_en, 1'b0);
    cyc(40);
    chk("t3_data", last_data, 8'h3C);
    chk("t3_vld_cycles", hi_cnt, 1);
    chk("t3_ferr", frame_err, 1);
    err_clr = 1'b1; cyc(1);
    err_clr = 1'b0; cyc(1);
    chk("t3_ferr_clr", frame_err, 0);

    // overrun with consumer stalled
    rx_ready = 1'b0;
    send_frame(8'h11, 1'b1, par_en, 1'b0);
    send_frame(8'h22, 1'b1, par_en, 1'b0);
    cyc(40);
    chk("t4_valid", rx_valid, 1);
    chk("t4_data", rx_data, 8'h11);
    chk("t4_oerr", overrun_err, 1);
    rx_ready = 1'b1; cyc(1);
    chk("t4_valid_fall", rx_valid, 0);
    chk("t4_xfer_data", last_data, 8'h11);

`ifdef UART_PARITY_EN
    send_frame(8'h07, 1'b1, 1'b1, 1'b0);
    cyc(40);
    chk("t5_bad_data", last_data, 8'h07);
    chk("t5_perr_set", parity_err, 1);
    err_clr = 1'b1; cyc(1);
    err_clr = 1'b0; cyc(1);
    chk("t5_perr_clr", parity_err, 0);
    send_frame(8'h07, 1'b1, 1'b1, 1'b1);
    cyc(40);
    chk("t5_good_perr", parity_err, 0);
`else
    send_frame(8'h07, 1'b1, 1'b0, 1'b0);
    cyc(40);
    chk("t5_data", last_data, 8'h07);
    chk("t5_perr_tied", parity_err, 0);
`endif

    // reset after bit 3 of a frame; also hold a byte in the register first
    rx_ready = 1'b0;
    send_frame(8'h99, 1'b1, par_en, 1'b1);
    cyc(20);
    chk("t6_pre_valid", rx_valid, 1);
    rxd = 1'b0; cyc(128);
    for (int i = 0; i < 4; i++) begin
      rxd = i[0]; cyc(128);
    end
    rst_n = 1'b0; rxd = 1'b1;
    cyc(3);
    chk("t6_rst_valid", rx_valid, 0);
    chk("t6_rst_data", rx_data, 0);
    chk("t6_rst_ferr", frame_err, 0);
    chk("t6_rst_oerr", overrun_err, 0);
    chk("t6_rst_perr", parity_err, 0);
    rst_n = 1'b1; rx_ready = 1'b1;
    cyc(200);
    hi_cnt = 0;
    send_frame(8'h5A, 1'b1, par_en, 1'b0);
    cyc(40);
    chk("t6_data", last_data, 8'h5A);
    chk("t6_vld_cycles", hi_cnt, 1);
    chk("t6_ferr", frame_err, 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
